// File: rtl/alu_sequencer_if.sv
// Request/grant and control-unit handshake bundle for alu_sequencer.
interface alu_sequencer_if;
  logic [1:0] req;
  logic [1:0] op0;
  logic [1:0] op1;
  logic [1:0] gnt;
  logic [1:0] done;
  logic       err;
  logic       busy;
  logic       bgn_as;
  logic       bgn_mul;
  logic       bgn_div;
  logic       s;
  logic       stop_as;
  logic       stop_mul;
  logic       stop_div;

  // slave: the sequencer itself
  modport slave (
    input  req, op0, op1, stop_as, stop_mul, stop_div,
    output gnt, done, err, busy, bgn_as, bgn_mul, bgn_div, s
  );

  // master: requesters plus control units driving the sequencer
  modport master (
    output req, op0, op1, stop_as, stop_mul, stop_div,
    input  gnt, done, err, busy, bgn_as, bgn_mul, bgn_div, s
  );
endinterface

// File: rtl/alu_sequencer.sv
// Two-requester round-robin sequencer that launches add/sub, mul or div
// control units and waits for their stop with a watchdog timeout.
module alu_sequencer #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           rst_b,
  alu_sequencer_if.slave bus
);
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

  state_t     state, nxt;
  logic       prio;
  logic       sel;
  logic       err_q;
  logic [1:0] opc;
  logic [7:0] wdog;
  logic       pick;
  logic       unit_stop;
  logic       wd_last;
  logic [1:0] sel_oh;

  always_comb begin
    pick = bus.req[1];
    if (bus.req == 2'b11) pick = prio;
  end

  // only the unit launched for the latched opcode may end the wait
  always_comb begin
    unit_stop = bus.stop_as;
    if (opc == 2'b10)      unit_stop = bus.stop_mul;
    else if (opc == 2'b11) unit_stop = bus.stop_div;
  end

  assign wd_last = (wdog == WD_LAST);
  assign sel_oh  = sel ? 2'b10 : 2'b01;

  always_ff @(posedge clk) begin
    if (!rst_b) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (|bus.req) nxt = START;
      START:   nxt = WAIT;
      WAIT:    if (unit_stop || wd_last) nxt = RESP;
      RESP:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      prio  <= 1'b0;
      sel   <= 1'b0;
      opc   <= 2'b00;
      wdog  <= 8'd0;
      err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (|bus.req) begin
          sel <= pick;
          opc <= pick ? bus.op1 : bus.op0;
        end
        START: wdog <= 8'd0;
        // completion wins over a simultaneous watchdog terminal
        WAIT: begin
          if (unit_stop)    err_q <= 1'b0;
          else if (wd_last) err_q <= 1'b1;
          else              wdog  <= wdog + 8'd1;
        end
        RESP:    prio <= ~sel;
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.gnt     = 2'b00;
    bus.done    = 2'b00;
    bus.err     = 1'b0;
    bus.busy    = (state != IDLE);
    bus.bgn_as  = 1'b0;
    bus.bgn_mul = 1'b0;
    bus.bgn_div = 1'b0;
    bus.s       = !(state != IDLE && opc == 2'b01);
    case (state)
      START: begin
        bus.gnt     = sel_oh;
        bus.bgn_as  = ~opc[1];
        bus.bgn_mul = (opc == 2'b10);
        bus.bgn_div = (opc == 2'b11);
      end
      WAIT: bus.gnt = sel_oh;
      RESP: begin
        bus.gnt  = sel_oh;
        bus.done = sel_oh;
        bus.err  = err_q;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: transaction-level reference model checked
// every cycle, plus hand-computed latency/grant/err expectations.
module tb_alu_sequencer;
  localparam int TIMEOUT = 4;

  logic clk = 1'b0;
  logic rst_b;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   chk_en = 1'b0;

  alu_sequencer_if bus();
  alu_sequencer #(.TIMEOUT(TIMEOUT)) dut (.clk(clk), .rst_b(rst_b), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: an accepted operation is a START cycle, then numbered WAIT
  // cycles until the unit's stop or the TIMEOUT-th one, then one RESP cycle.
  bit       m_act, m_fin, m_ferr, m_prio, m_k;
  bit [1:0] m_op;
  int       m_age;

  function automatic bit stop_for(input bit [1:0] op, input bit a, input bit m, input bit d);
    if (op[1] == 1'b0) return a;
    return (op == 2'b10) ? m : d;
  endfunction

  always @(posedge clk) begin
    if (!rst_b) begin
      m_act <= 0; m_fin <= 0; m_ferr <= 0; m_prio <= 0; m_k <= 0; m_op <= 0; m_age <= 0;
    end else if (!m_act) begin
      if (bus.req != 2'b00) begin
        m_act <= 1; m_fin <= 0; m_age <= 0;
        m_k   <= (bus.req == 2'b11) ? m_prio : bus.req[1];
        m_op  <= (((bus.req == 2'b11) ? m_prio : bus.req[1]) != 0) ? bus.op1 : bus.op0;
      end
    end else if (m_fin) begin
      m_act <= 0; m_fin <= 0; m_prio <= ~m_k;
    end else if (m_age == 0) begin
      m_age <= 1;
    end else if (stop_for(m_op, bus.stop_as, bus.stop_mul, bus.stop_div)) begin
      m_fin <= 1; m_ferr <= 0;
    end else if (m_age == TIMEOUT) begin
      m_fin <= 1; m_ferr <= 1;
    end else begin
      m_age <= m_age + 1;
    end
  end

  wire [1:0] e_gnt  = m_act ? (m_k ? 2'b10 : 2'b01) : 2'b00;
  wire       e_strt = m_act && !m_fin && m_age == 0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy",    int'(bus.busy),    int'(m_act));
      chk("gnt",     int'(bus.gnt),     int'(e_gnt));
      chk("done",    int'(bus.done),    m_fin ? int'(e_gnt) : 0);
      chk("err",     int'(bus.err),     int'(m_fin && m_ferr));
      chk("bgn_as",  int'(bus.bgn_as),  int'(e_strt && !m_op[1]));
      chk("bgn_mul", int'(bus.bgn_mul), int'(e_strt && m_op == 2'b10));
      chk("bgn_div", int'(bus.bgn_div), int'(e_strt && m_op == 2'b11));
      chk("s",       int'(bus.s),       int'(!(m_act && m_op == 2'b01)));
    end
  end

  // Called at a negedge. Drives one operation; stop_at = WAIT ordinal on which
  // the launched unit's stop is raised (0 = never). Returns at the done negedge.
  task automatic do_op(input bit [1:0] rq, input bit [1:0] o0, input bit [1:0] o1,
                       input int stop_at, input bit keep, input bit noise, input bit drop,
                       output int lat, output bit [1:0] d, output bit e,
                       output bit [1:0] g, output int unit, output bit s_at, output int nbgn);
    int bi = -1;
    bit fin = 0;
    lat = -1; d = 0; e = 0; g = 0; unit = 0; s_at = 0; nbgn = 0;
    bus.req = rq; bus.op0 = o0; bus.op1 = o1;
    for (int i = 1; i <= 100 && !fin; i++) begin
      @(negedge clk);
      bus.stop_as = 0; bus.stop_mul = 0; bus.stop_div = 0;
      if (bus.bgn_as || bus.bgn_mul || bus.bgn_div) begin
        nbgn++;
        if (bi < 0) begin
          bi = i; g = bus.gnt; s_at = bus.s;
          unit = bus.bgn_as ? 1 : (bus.bgn_mul ? 2 : 3);
          bus.op0 = ~o0; bus.op1 = ~o1;
          if (drop) bus.req = 2'b00;
        end
      end
      if (bi > 0 && noise && i - bi == 2) begin
        bus.stop_mul = 1; bus.stop_as = 1;
      end
      if (bi > 0 && stop_at > 0 && i - bi == stop_at) begin
        case (unit)
          1:       bus.stop_as  = 1;
          2:       bus.stop_mul = 1;
          default: bus.stop_div = 1;
        endcase
      end
      if (bus.done != 2'b00) begin
        fin = 1; lat = i; d = bus.done; e = bus.err;
        bus.op0 = o0; bus.op1 = o1;
        if (!keep) bus.req = 2'b00;
      end
    end
    if (!fin) chk("op_timeout", 0, 1);
  endtask

  int lat, unit, nbgn;
  bit [1:0] d, g;
  bit e, s_at;

  initial begin
    rst_b = 0;
    bus.req = 0; bus.op0 = 0; bus.op1 = 0;
    bus.stop_as = 0; bus.stop_mul = 0; bus.stop_div = 0;
    @(posedge clk);
    @(negedge clk);
    chk_en = 1;
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_gnt", int'(bus.gnt), 0);
    chk("rst_s", int'(bus.s), 1);
    @(negedge clk);
    rst_b = 1;
    @(negedge clk);

    // sub on requester 0, stop on third WAIT
    do_op(2'b01, 2'b01, 2'b00, 3, 0, 0, 0, lat, d, e, g, unit, s_at, nbgn);
    chk("sub_lat", lat, 5); chk("sub_done", int'(d), 1); chk("sub_err", int'(e), 0);
    chk("sub_s", int'(s_at), 0); chk("sub_unit", unit, 1); chk("sub_nbgn", nbgn, 1);
    @(negedge clk);

    // minimum latency: add on requester 1, stop on first WAIT
    do_op(2'b10, 2'b00, 2'b00, 1, 0, 0, 0, lat, d, e, g, unit, s_at, nbgn);
    chk("min_lat", lat, 3); chk("min_done", int'(d), 2); chk("min_s", int'(s_at), 1);
    @(negedge clk);

    // both requesting continuously: round-robin 0,1,0
    do_op(2'b11, 2'b10, 2'b11, 2, 1, 0, 0, lat, d, e, g, unit, s_at, nbgn);
    chk("rr1_gnt", int'(g), 1); chk("rr1_unit", unit, 2); chk("rr1_done", int'(d), 1);
    do_op(2'b11, 2'b10, 2'b11, 2, 1, 0, 0, lat, d, e, g, unit, s_at, nbgn);
    chk("rr2_gnt", int'(g), 2); chk("rr2_unit", unit, 3); chk("rr2_done", int'(d), 2);
    do_op(2'b11, 2'b10, 2'b11, 2, 0, 0, 0, lat, d, e, g, unit, s_at, nbgn);
    chk("rr3_gnt", int'(g), 1); chk("rr3_unit", unit, 2);
    @(negedge clk);

    // div without stop: TIMEOUT WAIT cycles then err
    do_op(2'b10, 2'b00, 2'b11, 0, 0, 0, 0, lat, d, e, g, unit, s_at, nbgn);
    chk("to_lat", lat, 6); chk("to_done", int'(d), 2); chk("to_err", int'(e), 1);
    @(negedge clk);

    // stop on the terminal WAIT cycle wins; foreign stops ignored
    do_op(2'b10, 2'b00, 2'b11, TIMEOUT, 0, 1, 0, lat, d, e, g, unit, s_at, nbgn);
    chk("edge_lat", lat, 6); chk("edge_done", int'(d), 2); chk("edge_err", int'(e), 0);
    @(negedge clk);

    // requester drops req after grant: operation still completes
    do_op(2'b01, 2'b01, 2'b00, 2, 0, 0, 1, lat, d, e, g, unit, s_at, nbgn);
    chk("drop_lat", lat, 4); chk("drop_done", int'(d), 1);

    // stops while idle are ignored
    bus.stop_div = 1; bus.stop_as = 1;
    @(negedge clk);
    @(negedge clk);
    chk("idle_busy", int'(bus.busy), 0);
    bus.stop_div = 0; bus.stop_as = 0;
    @(negedge clk);

    // reset in WAIT abandons the op; prio returns to requester 0
    bus.req = 2'b01; bus.op0 = 2'b00;
    for (int i = 0; i < 20 && !bus.bgn_as; i++) @(negedge clk);
    chk("rstw_bgn", int'(bus.bgn_as), 1);
    @(negedge clk);
    rst_b = 0; bus.req = 2'b00;
    @(negedge clk);
    chk("rstw_busy", int'(bus.busy), 0); chk("rstw_gnt", int'(bus.gnt), 0);
    chk("rstw_done", int'(bus.done), 0);
    @(negedge clk);
    rst_b = 1;
    do_op(2'b11, 2'b00, 2'b00, 1, 0, 0, 0, lat, d, e, g, unit, s_at, nbgn);
    chk("rstw_gnt0", int'(g), 1); chk("rstw_done0", int'(d), 1);
    @(negedge clk);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
